// File: rtl/sclk_serializer.sv
// Parallel-to-serial shifter clocked by an externally divided sclk.
// Data launches on sclk falls; the frame closes on the rise after the last bit.
module sclk_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             sdo,
   output logic             cs_n,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_sclk_d;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_sdo;

   logic             w_rise;
   logic             w_fall;
   logic             w_accept;
   logic             w_load;
   logic             w_first;
   logic [WIDTH-1:0] w_shift_nx;

   assign w_rise = sclk & ~r_sclk_d;
   assign w_fall = ~sclk & r_sclk_d;

   assign w_first    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
   assign w_shift_nx = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shift[WIDTH-1:1]};

   assign sdo = r_sdo;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      tx_ready = 1'b0;
      cs_n     = 1'b1;
      done     = 1'b0;
      w_accept = 1'b0;
      w_load   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               w_accept = 1'b1;
               w_next   = S_ARM;
            end
         end
         S_ARM: begin
            cs_n = 1'b0;
            if (w_fall) begin
               w_load = 1'b1;
               w_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            cs_n = 1'b0;
            if (w_fall && (r_cnt < CW'(WIDTH))) begin
               w_load = 1'b1;
            end else if (w_rise && (r_cnt == CW'(WIDTH))) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // sdo is cleared on the way into DONE so it idles low between frames
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sclk_d <= 1'b0;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_sdo    <= 1'b0;
      end else begin
         r_sclk_d <= sclk;
         if (w_accept) begin
            r_shift <= tx_data;
            r_cnt   <= '0;
         end
         if (w_load) begin
            r_sdo   <= w_first;
            r_shift <= w_shift_nx;
            r_cnt   <= r_cnt + CW'(1);
         end
         if (r_state == S_SHIFT && w_next == S_DONE) begin
            r_sdo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sclk_serializer.sv
// Bench for sclk_serializer: MSB-first and LSB-first instances in lockstep,
// with a receiver model that captures sdo on sclk rises inside a frame.
module tb_sclk_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic       sclk;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       rdy [2];
   logic       sdo [2];
   logic       cs  [2];
   logic       dn  [2];

   always #5 clk = ~clk;

   sclk_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .sclk(sclk),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy[0]),
      .sdo(sdo[0]), .cs_n(cs[0]), .done(dn[0])
   );

   sclk_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .sclk(sclk),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy[1]),
      .sdo(sdo[1]), .cs_n(cs[1]), .done(dn[1])
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // receiver model state
   int val [2];
   int nb  [2];
   bit seen_fall [2];
   bit prev_done [2];
   int q0[$];
   int q1[$];
   int tick_no = 0;
   int last_done_tick = 0;
   bit sclk_run;
   int ph = 0;

   // expected frame: bit count in the upper half, bits in wire order below
   function automatic int expf(input int d, input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return (8 << 16) | int'((d == 0) ? w : r);
   endfunction

   task automatic tick();
      @(negedge clk);
      tick_no++;
      for (int d = 0; d < 2; d++) begin
         if (prev_done[d]) chk("rdy_after_done", rdy[d], 1);
         prev_done[d] = dn[d];
         if (dn[d]) begin
            if (d == 0) q0.push_back((nb[d] << 16) | val[d]);
            else        q1.push_back((nb[d] << 16) | val[d]);
            last_done_tick = tick_no;
         end
         if (cs[d] !== 1'b0) begin
            val[d] = 0;
            nb[d] = 0;
            seen_fall[d] = 0;
         end
      end
      if (sclk_run) begin
         ph++;
         if (ph == 4) begin
            ph = 0;
            for (int d = 0; d < 2; d++) begin
               if (cs[d] === 1'b0) begin
                  if (!sclk && seen_fall[d]) begin
                     val[d] = (val[d] << 1) | int'(sdo[d]);
                     nb[d]++;
                  end else if (sclk) begin
                     seen_fall[d] = 1;
                  end
               end
            end
            sclk = ~sclk;
         end
      end
   endtask

   task automatic send(input logic [7:0] w, output int acc);
      bit ok;
      ok = 0;
      acc = 0;
      tx_data = w;
      tx_valid = 1'b1;
      for (int k = 0; k < 2000 && !ok; k++) begin
         if (rdy[0]) begin
            acc = tick_no;
            ok = 1;
         end
         tick();
      end
      tx_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_frames(input int n);
      int k;
      k = 0;
      while ((q0.size() < n || q1.size() < n) && k < 3000) begin
         tick();
         k++;
      end
      repeat (3) tick();
      chk("nframes_msb", q0.size(), n);
      chk("nframes_lsb", q1.size(), n);
   endtask

   task automatic chk_last(input string tag, input logic [7:0] w);
      chk({tag, "_msb"}, (q0.size() > 0) ? q0[q0.size()-1] : -1, expf(0, w));
      chk({tag, "_lsb"}, (q1.size() > 0) ? q1[q1.size()-1] : -1, expf(1, w));
   endtask

   initial begin
      int a;
      int a2;
      int nf;
      logic [7:0] w;
      reset = 1'b0;
      sclk = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      sclk_run = 1'b1;
      for (int d = 0; d < 2; d++) begin
         val[d] = 0;
         nb[d] = 0;
         seen_fall[d] = 0;
         prev_done[d] = 0;
      end

      repeat (3) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            chk("rst_rdy", rdy[d], 1);
            chk("rst_cs", cs[d], 1);
            chk("rst_sdo", sdo[d], 0);
            chk("rst_done", dn[d], 0);
         end
      end
      reset = 1'b1;

      send(8'hA5, a);
      wait_frames(1);
      chk_last("a5", 8'hA5);

      send(8'h01, a);
      wait_frames(2);
      chk_last("x01", 8'h01);

      send(8'h3C, a);
      send(8'hFF, a2);
      chk("b2b_gap", a2 - last_done_tick, 1);
      wait_frames(4);
      chk("busy_first", q0[2], expf(0, 8'h3C));
      chk_last("busy_ff", 8'hFF);

      send(8'h5A, a);
      for (int k = 0; k < 500 && nb[0] < 3; k++) tick();
      chk("mid_bits", nb[0], 3);
      #2 reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("mid_cs", cs[d], 1);
         chk("mid_rdy", rdy[d], 1);
         chk("mid_sdo", sdo[d], 0);
         chk("mid_done", dn[d], 0);
      end
      repeat (5) tick();
      reset = 1'b1;
      repeat (5) tick();
      chk("mid_nodone", q0.size(), 4);
      send(8'h81, a);
      wait_frames(5);
      chk_last("after_rst", 8'h81);

      send(8'hC3, a);
      sclk_run = 1'b0;
      repeat (40) tick();
      for (int d = 0; d < 2; d++) begin
         chk("stall_cs", cs[d], 0);
         chk("stall_rdy", rdy[d], 0);
         chk("stall_sdo", sdo[d], 0);
      end
      sclk_run = 1'b1;
      wait_frames(6);
      chk_last("stall", 8'hC3);

      nf = 6;
      for (int i = 0; i < 6; i++) begin
         w = 8'($urandom);
         send(w, a);
         nf++;
         wait_frames(nf);
         chk_last("rand", w);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sclk_serializer.md
SCLK_SERIALIZER -- requirements
Module: sclk_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per transfer (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift MSB first and 0 = shift LSB first.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port sclk  input  1  divided serial clock from the clock divider, synchronous to clk.
REQ-006 SHALL have port tx_data  input  WIDTH  parallel word to send.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid.
REQ-008 SHALL have port tx_ready  output  1  block can accept a word.
REQ-009 SHALL have port sdo  output  1  serial data out, changes only on sclk falling edges.
REQ-010 SHALL have port cs_n  output  1  active-low frame select, low for the whole transfer.
REQ-011 SHALL have port done  output  1  one-clk pulse at transfer end.

Function
REQ-012 SHALL register sclk into sclk_d each clk; rise = sclk & ~sclk_d; fall = ~sclk & sclk_d; edges act one clk after the sclk transition.
REQ-013 SHALL implement states IDLE, ARM, SHIFT, DONE.
REQ-014 IDLE: tx_ready=1, cs_n=1; tx_valid&tx_ready captures tx_data into shift register, clears bit counter, goes to ARM next clk.
REQ-015 ARM: tx_ready=0, cs_n=0 (one clk after accept); on first fall drive first bit (MSB if MSB_FIRST=1 else LSB) onto sdo, counter=1, go to SHIFT.
REQ-016 SHIFT: on each fall with counter<WIDTH, drive next bit and increment counter; rises before a fall are ignored for data.
REQ-017 SHIFT: on the first rise after counter reaches WIDTH (last bit sampled by receiver), go to DONE.
REQ-018 DONE: one clk; done=1, cs_n=1, tx_ready=0, sdo=0; next state IDLE.
REQ-019 Bit counter width SHALL be clog2(WIDTH+1); no wrap permitted within a transfer.
REQ-020 tx_valid while tx_ready=0 SHALL be ignored; tx_data sampled only at acceptance.
REQ-021 If sclk has no edges, block SHALL hold current state indefinitely (no timeout).
REQ-022 Back-to-back: earliest next acceptance is the IDLE cycle immediately after DONE.
REQ-023 A rise and fall cannot coincide by construction; sclk held constant produces no edge.

Reset
REQ-024 reset=0 SHALL immediately (asynchronously) force state=IDLE, sclk_d=0, counter=0, shift register=0, tx_ready=1, cs_n=1, sdo=0, done=0.
REQ-025 Reset mid-transfer SHALL abort it with no done pulse; first transfer after release is complete and correct.
REQ-026 A spurious rise detected on release (sclk=1, sclk_d=0) SHALL have no effect in IDLE.

Verification
REQ-027 Reset: hold reset=0 for 3 clk -> tx_ready=1, cs_n=1, sdo=0, done=0 throughout.
REQ-028 WIDTH=8, MSB_FIRST=1, bench sclk period 8 clk, send 0xA5 -> sdo at successive sclk rises = 1,0,1,0,0,1,0,1; cs_n low throughout; exactly one done pulse; tx_ready=1 one clk after done.
REQ-029 MSB_FIRST=0, send 0x01 -> sdo at rises = 1,0,0,0,0,0,0,0.
REQ-030 Busy: accept 0x3C, then hold tx_valid=1 with 0xFF during transfer -> serial word is 0x3C; 0xFF accepted only in the IDLE cycle after done and sent complete.
REQ-031 Reset mid-op: assert reset=0 after 3 bits -> cs_n=1, tx_ready=1 asynchronously, no done; then send 0x81 -> full 1,0,0,0,0,0,0,1.
REQ-032 Stalled sclk: accept a word, freeze sclk -> remains in ARM, cs_n=0, tx_ready=0; resume sclk -> transfer completes normally.
